sipo_rx_ctrl: RTL and testbench

Receive-side controller that sequences a WIDTH-bit D-FF serial-in/parallel-out shift chain.
- Gates shifting on a bit strobe, counts bits per frame, and transfers each completed word into an output holding register.
- Holding register has a valid/ready handshake. Overrun is flagged when a word completes while the holder is still full.
- Sits between a serial bit source and a parallel consumer.

---
 rtl/sipo_rx_pkg.sv | 12 +
 rtl/sipo_shreg.sv | 36 +++
 rtl/sipo_rx_ctrl.sv | 140 ++++++++++++++
 tb/tb_sipo_rx_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sipo_rx_pkg.sv
// Shared types and defaults for the SIPO receive controller.
package sipo_rx_pkg;

    localparam int unsigned SIPO_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        PAR   = 2'b10
    } state_t;

endpackage

// File: rtl/sipo_shreg.sv
// WIDTH-bit enable-gated serial-in/parallel-out chain built as a row of D-FFs;
// d enters at q[0], so the oldest bit ends up at q[WIDTH-1].
module sipo_shreg
    import sipo_rx_pkg::*;
#(
    parameter int unsigned WIDTH = SIPO_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             d,
    output logic [WIDTH-1:0] q
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_ff
        logic ff;
        logic ff_d;

        if (i == 0) begin : g_head
            assign ff_d = d;
        end else begin : g_link
            assign ff_d = q[i-1];
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                ff <= 1'b0;
            end else if (en) begin
                ff <= ff_d;
            end
        end

        assign q[i] = ff;
    end

endmodule

// File: rtl/sipo_rx_ctrl.sv
// Receive controller: sequences the SIPO chain per frame and hands words to a
// valid/ready holding register. Build macro SIPO_RX_PARITY_CHK_EN adds an even-parity bit.
module sipo_rx_ctrl
    import sipo_rx_pkg::*;
#(
    parameter int unsigned WIDTH = SIPO_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sin,
    input  logic             sin_vld,
    output logic [WIDTH-1:0] pdata,
    output logic             pvalid,
    input  logic             pready,
    output logic             busy,
    output logic             overrun,
    output logic             par_err
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             shift_en_c;
    logic             deliver_c;
    logic             par_c;
    logic             holder_free_c;
    logic [WIDTH-1:0] chain;
    logic [WIDTH-1:0] word_c;

    sipo_shreg #(
        .WIDTH (WIDTH)
    ) u_shreg (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (shift_en_c),
        .d     (sin),
        .q     (chain)
    );

`ifdef SIPO_RX_PARITY_CHK_EN
    // Data is already settled in the chain; the strobed bit is the parity bit.
    assign word_c = chain;
    assign par_c  = (^chain) ^ sin;
`else
    // Deliver on the last data strobe, so splice the incoming bit in directly.
    logic unused_chain_msb;
    assign unused_chain_msb = chain[WIDTH-1];
    assign word_c = {chain[WIDTH-2:0], sin};
    assign par_c  = 1'b0;
`endif

    assign holder_free_c = !pvalid || pready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next state; start takes priority everywhere and discards any partial frame.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        shift_en_c = 1'b0;
        deliver_c  = 1'b0;
        if (start) begin
            state_nxt = SHIFT;
            cnt_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = IDLE;
                end
                SHIFT: begin
                    if (sin_vld) begin
                        shift_en_c = 1'b1;
                        if (cnt == LAST_CNT) begin
                            cnt_nxt = '0;
`ifdef SIPO_RX_PARITY_CHK_EN
                            state_nxt = PAR;
`else
                            state_nxt = IDLE;
                            deliver_c = 1'b1;
`endif
                        end else begin
                            cnt_nxt = cnt + CNT_W'(1);
                        end
                    end
                end
`ifdef SIPO_RX_PARITY_CHK_EN
                PAR: begin
                    if (sin_vld) begin
                        deliver_c = 1'b1;
                        state_nxt = IDLE;
                    end
                end
`endif
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Holding register, handshake and overrun pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy    <= 1'b0;
            pdata   <= '0;
            pvalid  <= 1'b0;
            overrun <= 1'b0;
            par_err <= 1'b0;
        end else begin
            busy    <= (state_nxt != IDLE);
            overrun <= 1'b0;
            if (deliver_c) begin
                if (holder_free_c) begin
                    pdata   <= word_c;
                    pvalid  <= 1'b1;
                    par_err <= par_c;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (pvalid && pready) begin
                pvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sipo_rx_ctrl.sv
// Self-checking bench for sipo_rx_ctrl: directed scenarios plus random traffic
// against a frame-level model (bit queue + holder). Honours SIPO_RX_PARITY_CHK_EN.
module tb_sipo_rx_ctrl;

    localparam int unsigned W = 4;
`ifdef SIPO_RX_PARITY_CHK_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         sin;
    logic         sin_vld;
    logic [W-1:0] pdata;
    logic         pvalid;
    logic         pready;
    logic         busy;
    logic         overrun;
    logic         par_err;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    bit           m_active;
    bit           m_bits[$];
    bit           m_hv;
    logic [W-1:0] m_hd;
    bit           m_hp;
    bit           m_ovr;

    sipo_rx_ctrl #(
        .WIDTH (W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .sin     (sin),
        .sin_vld (sin_vld),
        .pdata   (pdata),
        .pvalid  (pvalid),
        .pready  (pready),
        .busy    (busy),
        .overrun (overrun),
        .par_err (par_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        m_bits.delete();
        m_hv  = 1'b0;
        m_hd  = '0;
        m_hp  = 1'b0;
        m_ovr = 1'b0;
    endtask

    // One rising edge of the frame-level behaviour, using the current inputs.
    task automatic model_step();
        bit           accept;
        bit           done;
        logic [W-1:0] w;
        bit           pe;
        if (!rst_n) begin
            model_reset();
            return;
        end
        m_ovr  = 1'b0;
        accept = m_hv && pready;
        done   = 1'b0;
        w      = '0;
        pe     = 1'b0;
        if (start) begin
            m_active = 1'b1;
            m_bits.delete();
        end else if (m_active && sin_vld) begin
            if (m_bits.size() < W) begin
                m_bits.push_back(sin);
                if (!PAR_EN && m_bits.size() == W) done = 1'b1;
            end else begin
                done = 1'b1;
            end
            if (done) begin
                foreach (m_bits[i]) w = W'((w << 1) | W'(m_bits[i]));
                if (PAR_EN) pe = ((($countones(w) + int'(sin)) % 2) == 1);
                m_active = 1'b0;
                m_bits.delete();
            end
        end
        if (done) begin
            if (!m_hv || accept) begin
                m_hd = w;
                m_hv = 1'b1;
                m_hp = pe;
            end else begin
                m_ovr = 1'b1;
            end
        end else if (accept) begin
            m_hv = 1'b0;
        end
    endtask

    task automatic check_outputs();
        check_eq("pvalid", 32'(pvalid), 32'(m_hv));
        check_eq("pdata", 32'(pdata), 32'(m_hd));
        check_eq("busy", 32'(busy), 32'(m_active));
        check_eq("overrun", 32'(overrun), 32'(m_ovr));
        if (m_hv) check_eq("par_err", 32'(par_err), 32'(m_hp));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_outputs();
    endtask

    task automatic strobe_bit(input bit b, input int gap);
        repeat (gap) begin
            sin_vld = 1'b0;
            sin     = 1'($urandom % 2);
            tick();
        end
        sin_vld = 1'b1;
        sin     = b;
        tick();
        sin_vld = 1'b0;
    endtask

    // Full frame, MSB first; rdy_last raises pready only on the delivery edge.
    task automatic send_word(input logic [W-1:0] w, input int gap, input bit pbit, input bit rdy_last);
        start   = 1'b1;
        sin_vld = 1'($urandom % 2);
        sin     = 1'($urandom % 2);
        tick();
        start = 1'b0;
        for (int i = W - 1; i >= 0; i--) begin
            if (rdy_last && !PAR_EN && i == 0) pready = 1'b1;
            strobe_bit(w[i], gap);
        end
        if (PAR_EN) begin
            if (rdy_last) pready = 1'b1;
            strobe_bit(pbit, gap);
        end
        if (rdy_last) pready = 1'b0;
    endtask

    initial begin
        rst_n   = 1'b1;
        start   = 1'b0;
        sin     = 1'b0;
        sin_vld = 1'b0;
        pready  = 1'b0;
        model_reset();
        #2 rst_n = 1'b0;
        #1;
        check_outputs();
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // basic frame, consumer always ready
        pready = 1'b1;
        send_word(4'b1011, 0, 1'b1, 1'b0);
        check_eq("t1_pdata", 32'(pdata), 32'h0000_000b);
        check_eq("t1_busy", 32'(busy), 32'h0);
        tick();
        check_eq("t1_drop", 32'(pvalid), 32'h0);

        // sparse strobes with noise on sin between them
        send_word(4'b0110, 2, 1'b0, 1'b0);
        check_eq("t2_pdata", 32'(pdata), 32'h0000_0006);
        tick();

        // overrun while holder is full
        pready = 1'b0;
        send_word(4'hA, 1, 1'b0, 1'b0);
        send_word(4'h5, 1, 1'b0, 1'b0);
        check_eq("t3_ovr", 32'(overrun), 32'h1);
        check_eq("t3_hold", 32'(pdata), 32'h0000_000a);
        tick();
        check_eq("t3_ovr_end", 32'(overrun), 32'h0);
        pready = 1'b1;
        tick();
        pready = 1'b0;
        check_eq("t3_accept", 32'(pvalid), 32'h0);
        tick();

        // accept and deliver on the same edge
        send_word(4'h3, 0, 1'b0, 1'b0);
        send_word(4'hC, 0, 1'b0, 1'b1);
        check_eq("t4_valid", 32'(pvalid), 32'h1);
        check_eq("t4_pdata", 32'(pdata), 32'h0000_000c);
        check_eq("t4_ovr", 32'(overrun), 32'h0);
        pready = 1'b1;
        tick();
        pready = 1'b0;

        // abort via restart, then async reset mid-frame
        start = 1'b1;
        tick();
        start = 1'b0;
        strobe_bit(1'b1, 0);
        strobe_bit(1'b0, 0);
        send_word(4'hC, 0, 1'b0, 1'b0);
        check_eq("t5_pdata", 32'(pdata), 32'h0000_000c);
        start = 1'b1;
        tick();
        start = 1'b0;
        strobe_bit(1'b1, 0);
        strobe_bit(1'b0, 0);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        check_eq("t5_rst_busy", 32'(busy), 32'h0);
        tick();
        rst_n = 1'b1;
        tick();

`ifdef SIPO_RX_PARITY_CHK_EN
        pready = 1'b1;
        send_word(4'b1011, 0, 1'b1, 1'b0);
        check_eq("t6_par_ok", 32'(par_err), 32'h0);
        tick();
        send_word(4'b1011, 0, 1'b0, 1'b0);
        check_eq("t6_par_bad", 32'(par_err), 32'h1);
        tick();
`endif

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            start   = ($urandom_range(0, 29) == 0);
            sin_vld = 1'($urandom % 2);
            sin     = 1'($urandom % 2);
            pready  = ($urandom_range(0, 3) != 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
